// File: rtl/hdmi_pixel_feeder.sv
// hdmi_pixel_feeder: buffers an incoming RGB pixel stream in a FIFO and
// presents it to the HDMI transmitter aligned to the transmitter's cntX/cntY
// raster. It locks a frame on its start-of-frame marker, starts streaming at
// a frame boundary once enough pixels are buffered, and drops back to hunting
// for the next start-of-frame on underflow or a misplaced frame marker.
module hdmi_pixel_feeder #(
  parameter int          h_pixel     = 640,
  parameter int          h_tot_pixel = 800,
  parameter int          v_pixel     = 480,
  parameter int          v_tot_pixel = 525,
  parameter int          ADDR_W      = 10,
  parameter int          PREFILL     = 512,
  parameter logic [23:0] BLANK_RGB   = 24'h000000
) (
  input  logic              clk_low,
  input  logic              reset,
  input  logic [23:0]       pix_in_data,
  input  logic              pix_in_sof,
  input  logic              pix_in_valid,
  output logic              pix_in_ready,
  input  logic [25:0]       cntX,
  input  logic [25:0]       cntY,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              synced,
  output logic              underflow,
  output logic              sync_err,
  output logic [ADDR_W:0]   level
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [ADDR_W:0] FULL_LVL    = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] PREFILL_LVL = (ADDR_W + 1)'(PREFILL);
  localparam logic [ADDR_W:0] PTR_ONE     = (ADDR_W + 1)'(1);

  // Raster limits kept at the full counter width so no counter bit is ignored.
  localparam logic [25:0] X_ACTIVE = 26'(h_pixel);
  localparam logic [25:0] Y_ACTIVE = 26'(v_pixel);
  localparam logic [25:0] X_LAST   = 26'(h_tot_pixel - 1);
  localparam logic [25:0] Y_LAST   = 26'(v_tot_pixel - 1);

  localparam logic [1:0] ST_WAIT_SOF   = 2'd0;
  localparam logic [1:0] ST_WAIT_FRAME = 2'd1;
  localparam logic [1:0] ST_STREAM     = 2'd2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]        state_q,     state_d;
  logic [ADDR_W:0]   wr_ptr_q,    wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q,    rd_ptr_d;
  logic [23:0]       rgb_q,       rgb_d;
  logic              underflow_q, underflow_d;
  logic              sync_err_q,  sync_err_d;

  // Each entry is {sof, rgb}.
  logic [24:0]       mem_q [DEPTH];

  // --------------------------------------------------------------------------
  // Combinational status
  // --------------------------------------------------------------------------
  logic [ADDR_W:0]   level_w;
  logic              full_w;
  logic              empty_w;
  logic              active_w;
  logic              frame_edge_w;
  logic              at_origin_w;
  logic [24:0]       head_w;
  logic              accept_w;
  logic              wr_en_w;
  logic              pop_req_w;
  logic              err_under_w;
  logic              err_sync_w;
  logic              err_w;
  logic              pop_w;

  // FIFO occupancy and raster-position decode.
  always_comb begin
    level_w      = wr_ptr_q - rd_ptr_q;
    full_w       = (level_w == FULL_LVL);
    empty_w      = (level_w == '0);
    active_w     = (cntX < X_ACTIVE) && (cntY < Y_ACTIVE);
    frame_edge_w = (cntX == X_LAST) && (cntY == Y_LAST);
    at_origin_w  = (cntX == '0) && (cntY == '0);
    head_w       = mem_q[rd_ptr_q[ADDR_W-1:0]];
  end

  // Handshake, write enable, and pop/error qualification.
  always_comb begin
    // While hunting for a frame start every beat is taken so that stale
    // mid-frame pixels drain out of the source; only a sof beat is kept.
    pix_in_ready = !reset && ((state_q == ST_WAIT_SOF) || !full_w);
    accept_w     = pix_in_valid && pix_in_ready;

    pop_req_w    = (state_q == ST_STREAM) && active_w;
    err_under_w  = pop_req_w && empty_w;
    // The head must carry sof exactly at the raster origin and nowhere else.
    err_sync_w   = pop_req_w && !empty_w && (head_w[24] != at_origin_w);
    err_w        = err_under_w || err_sync_w;
    pop_w        = pop_req_w && !err_w;

    // A push coinciding with an error is dropped along with the flush.
    wr_en_w      = accept_w && !err_w &&
                   ((state_q != ST_WAIT_SOF) || pix_in_sof);
  end

  // Next-state logic for pointers, output pixel, sticky flags and the FSM.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q + (wr_en_w ? PTR_ONE : '0);
    rd_ptr_d    = rd_ptr_q + (pop_w ? PTR_ONE : '0);
    rgb_d       = pop_w ? head_w[23:0] : BLANK_RGB;
    underflow_d = underflow_q || err_under_w;
    sync_err_d  = sync_err_q || err_sync_w;

    // Flush: read pointer catches up with the (unchanged) write pointer.
    if (err_w) begin
      rd_ptr_d = wr_ptr_q;
    end

    case (state_q)
      ST_WAIT_SOF: begin
        // In this state a write only happens for a sof beat.
        if (wr_en_w) begin
          state_d = ST_WAIT_FRAME;
        end
      end
      ST_WAIT_FRAME: begin
        if (frame_edge_w && (level_w >= PREFILL_LVL)) begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (err_w) begin
          state_d = ST_WAIT_SOF;
        end
      end
      default: begin
        state_d = ST_WAIT_SOF;
      end
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk_low) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= ST_WAIT_SOF;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rgb_q       <= '0;
      underflow_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rgb_q       <= rgb_d;
      underflow_q <= underflow_d;
      sync_err_q  <= sync_err_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk_low) begin
    // NOTE: the storage array has no reset; emptiness is defined by the
    // pointers, so stale contents are never observed and the array can map
    // onto RAM.
    if (wr_en_w) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= {pix_in_sof, pix_in_data};
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign red       = rgb_q[23:16];
  assign green     = rgb_q[15:8];
  assign blue      = rgb_q[7:0];
  assign synced    = (state_q == ST_STREAM);
  assign underflow = underflow_q;
  assign sync_err  = sync_err_q;
  assign level     = level_w;

endmodule
